// File: rtl/i2c_target_regfile.sv
// I2C target with a REG_DEPTH x 8 register file, pointer byte, auto-increment and local side port.
// Optional SCL-low bus timeout is compiled in when I2C_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0]  DEVICE_ADDR    = 7'h2A,
    parameter int unsigned REG_DEPTH      = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         scl_in,
    input  logic                         sda_in,
    output logic                         sda_oe,
    input  logic                         local_wr_en,
    input  logic [$clog2(REG_DEPTH)-1:0] local_addr,
    input  logic [7:0]                   local_wr_data,
    output logic [7:0]                   local_rd_data,
    output logic                         busy,
    output logic                         wr_strobe,
    output logic [$clog2(REG_DEPTH)-1:0] wr_index
);
    localparam int unsigned PW = $clog2(REG_DEPTH);

    if (REG_DEPTH < 2 || REG_DEPTH > 16 || (REG_DEPTH & (REG_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("REG_DEPTH must be a power of two in 2..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, timeout;

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, tx_q, tx_d, rx_byte;
    logic [PW-1:0] ptr_q, ptr_d, reg_idx, wr_index_q;
    logic          sda_oe_q, sda_oe_d, busy_q, busy_d, rd_nack_q, rd_nack_d;
    logic          reg_we, wr_strobe_q;
    logic [7:0]    regs_q [REG_DEPTH];

    // Synchronisers reset to 1 so the idle bus shows no spurious edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (state_q == StIdle || scl_s) begin
            to_cnt_q <= '0;
        end else if (!timeout) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q != StIdle) && !scl_s && (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rd_nack_d = rd_nack_q;
        reg_we    = 1'b0;
        reg_idx   = ptr_q;
        if (stop_det || timeout) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == StPtr) begin
                            ptr_d = rx_byte[PW-1:0];
                        end
                        if (bit_cnt_q == 4'd7 && state_q == StWdata) begin
                            reg_we = 1'b1;
                            ptr_d  = ptr_q + PW'(1);
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == StPtr) begin
                            state_d = StPtrAck;
                        end else if (state_q == StWdata) begin
                            state_d = StWdataAck;
                        end else if (shift_q[7:1] == DEVICE_ADDR) begin
                            busy_d  = 1'b1;
                            state_d = StAddrAck;
                        end else begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            tx_d     = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            state_d  = StRdata;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StPtr;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StWdata;
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        ptr_d     = ptr_q + PW'(1);
                        rd_nack_d = 1'b0;
                        state_d   = StRdataAck;
                    end else if (scl_fall) begin
                        tx_d     = {tx_q[6:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
                StRdataAck: begin
                    // A NACK is sticky: further clocks are ignored until STOP/START.
                    if (scl_rise) begin
                        rd_nack_d = rd_nack_q | sda_s;
                    end else if (scl_fall && !rd_nack_q) begin
                        tx_d      = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd0;
                        state_d   = StRdata;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rd_nack_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rd_nack_q   <= rd_nack_d;
            wr_strobe_q <= reg_we;
            if (reg_we) begin
                wr_index_q <= reg_idx;
            end
        end
    end

    // The I2C write is issued last so it wins a same-register collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (local_wr_en) begin
                regs_q[local_addr] <= local_wr_data;
            end
            if (reg_we) begin
                regs_q[reg_idx] <= rx_byte;
            end
        end
    end

    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign wr_strobe     = wr_strobe_q;
    assign wr_index      = wr_index_q;
    assign local_rd_data = regs_q[local_addr];

endmodule
